// File: rtl/div_iter_param_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_iter_param_pkg
// Brief   : Shared state codes, handshake constants and default width for the
//           iterative divider.
// Revision: 1.0 - initial release
// ============================================================================
package div_iter_param_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    localparam logic [1:0] c_DIV_FREE    = 2'b00;
    localparam logic [1:0] c_DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] c_DIV_ON      = 2'b10;
    localparam logic [1:0] c_DIV_END     = 2'b11;

    localparam logic c_DIV_RESULT_READY     = 1'b1;
    localparam logic c_DIV_RESULT_NOT_READY = 1'b0;
    localparam logic c_DIV_START            = 1'b1;
    localparam logic c_DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        ST_FREE    = c_DIV_FREE,
        ST_BY_ZERO = c_DIV_BY_ZERO,
        ST_ON      = c_DIV_ON,
        ST_END     = c_DIV_END
    } div_state_e;

endpackage : div_iter_param_pkg
`default_nettype wire

// File: rtl/div_iter_param_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Brief   : One restoring-division step: shift in the next dividend bit and
//           trial-subtract the divisor on WIDTH+1 bits.
// Revision: 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_partial,
    input  logic             i_dividend_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_partial,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // partial < divisor holds on entry, so WIDTH+1 bits cannot overflow and
    // the difference MSB is a reliable borrow flag.
    assign w_shifted = {i_partial, i_dividend_msb};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign o_q_bit   = ~w_diff[WIDTH];
    assign o_partial = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule : div_step
`default_nettype wire

// File: rtl/div_iter_param.sv
`default_nettype none
// ============================================================================
// Module  : div_iter_param
// Brief   : Parametrised iterative restoring divider with divide-by-zero flag,
//           busy indication, annul support and signed fixup.
// Revision: 1.0 - initial release
// ============================================================================
module div_iter_param
    import div_iter_param_pkg::*;
#(
    parameter int WIDTH     = c_DEFAULT_WIDTH,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata_1_i,
    input  logic [WIDTH-1:0]   opdata_2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               div_by_zero_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e         r_state_q, w_state_d;
    logic [CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [WIDTH-1:0]   r_dividend_q, w_dividend_d;
    logic [WIDTH-1:0]   r_partial_q, w_partial_d;
    logic [WIDTH-1:0]   r_divisor_q, w_divisor_d;
    logic               r_neg_quot_q, w_neg_quot_d;
    logic               r_neg_rem_q, w_neg_rem_d;
    logic [2*WIDTH-1:0] r_result_q, w_result_d;
    logic               r_ready_q, w_ready_d;
    logic               r_dbz_q, w_dbz_d;
    logic               r_busy_q, w_busy_d;

    logic               w_signed_mode;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [WIDTH-1:0]   w_op1_mag;
    logic [WIDTH-1:0]   w_op2_mag;
    logic [WIDTH-1:0]   w_step_partial;
    logic               w_step_q_bit;
    logic [WIDTH-1:0]   w_quot_raw;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed_mode = (SIGNED_EN != 0) && signed_div_i;
    assign w_op1_neg     = w_signed_mode & opdata_1_i[WIDTH-1];
    assign w_op2_neg     = w_signed_mode & opdata_2_i[WIDTH-1];
    assign w_op1_mag     = w_op1_neg ? ({WIDTH{1'b0}} - opdata_1_i) : opdata_1_i;
    assign w_op2_mag     = w_op2_neg ? ({WIDTH{1'b0}} - opdata_2_i) : opdata_2_i;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_partial      (r_partial_q),
        .i_dividend_msb (r_dividend_q[WIDTH-1]),
        .i_divisor      (r_divisor_q),
        .o_partial      (w_step_partial),
        .o_q_bit        (w_step_q_bit)
    );

    // Dividend bits shift out the top while quotient bits fill from the bottom.
    assign w_quot_raw = {r_dividend_q[WIDTH-2:0], w_step_q_bit};
    assign w_quot_fix = r_neg_quot_q ? ({WIDTH{1'b0}} - w_quot_raw) : w_quot_raw;
    assign w_rem_fix  = r_neg_rem_q ? ({WIDTH{1'b0}} - w_step_partial) : w_step_partial;

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_dividend_d = r_dividend_q;
        w_partial_d  = r_partial_q;
        w_divisor_d  = r_divisor_q;
        w_neg_quot_d = r_neg_quot_q;
        w_neg_rem_d  = r_neg_rem_q;
        w_result_d   = r_result_q;
        w_ready_d    = r_ready_q;
        w_dbz_d      = r_dbz_q;
        w_busy_d     = r_busy_q;

        case (r_state_q)
            ST_FREE: begin
                if ((start_i == c_DIV_START) && !annul_i) begin
                    w_divisor_d  = w_op2_mag;
                    w_dividend_d = w_op1_mag;
                    w_partial_d  = '0;
                    w_cnt_d      = '0;
                    w_neg_quot_d = w_op1_neg ^ w_op2_neg;
                    w_neg_rem_d  = w_op1_neg;
                    w_busy_d     = 1'b1;
                    w_state_d    = (opdata_2_i == '0) ? ST_BY_ZERO : ST_ON;
                end
            end
            ST_BY_ZERO: begin
                w_busy_d   = 1'b0;
                w_result_d = '0;
                if (annul_i) begin
                    w_state_d = ST_FREE;
                end else begin
                    w_dbz_d   = 1'b1;
                    w_state_d = ST_END;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    w_busy_d   = 1'b0;
                    w_result_d = '0;
                    w_state_d  = ST_FREE;
                end else begin
                    w_dividend_d = w_quot_raw;
                    w_partial_d  = w_step_partial;
                    w_cnt_d      = r_cnt_q + 1'b1;
                    if (r_cnt_q == CNT_W'(WIDTH - 1)) begin
                        w_result_d = {w_rem_fix, w_quot_fix};
                        w_busy_d   = 1'b0;
                        w_state_d  = ST_END;
                    end
                end
            end
            ST_END: begin
                // Ready is always shown for at least one cycle before release.
                if (r_ready_q != c_DIV_RESULT_READY) begin
                    w_ready_d = c_DIV_RESULT_READY;
                end else if (start_i == c_DIV_STOP) begin
                    w_ready_d  = c_DIV_RESULT_NOT_READY;
                    w_result_d = '0;
                    w_dbz_d    = 1'b0;
                    w_state_d  = ST_FREE;
                end
            end
            default: begin
                w_state_d = ST_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_FREE;
            r_cnt_q      <= '0;
            r_dividend_q <= '0;
            r_partial_q  <= '0;
            r_divisor_q  <= '0;
            r_neg_quot_q <= 1'b0;
            r_neg_rem_q  <= 1'b0;
            r_result_q   <= '0;
            r_ready_q    <= c_DIV_RESULT_NOT_READY;
            r_dbz_q      <= 1'b0;
            r_busy_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_dividend_q <= w_dividend_d;
            r_partial_q  <= w_partial_d;
            r_divisor_q  <= w_divisor_d;
            r_neg_quot_q <= w_neg_quot_d;
            r_neg_rem_q  <= w_neg_rem_d;
            r_result_q   <= w_result_d;
            r_ready_q    <= w_ready_d;
            r_dbz_q      <= w_dbz_d;
            r_busy_q     <= w_busy_d;
        end
    end

    assign result_o      = r_result_q;
    assign ready_o       = r_ready_q;
    assign div_by_zero_o = r_dbz_q;
    assign busy_o        = r_busy_q;

endmodule : div_iter_param
`default_nettype wire

// File: tb/tb_div_iter_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_iter_param
// Brief   : Self-checking bench for div_iter_param (32-bit signed and 8-bit
//           unsigned-only instances) against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_div_iter_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        s32 = 1'b0, st32 = 1'b0, an32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] res32;
    logic        rdy32, dbz32, busy32;

    logic        s8 = 1'b0, st8 = 1'b0, an8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] res8;
    logic        rdy8, dbz8, busy8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_iter_param #(.WIDTH(32), .SIGNED_EN(1)) u_dut32 (
        .clk(clk), .rst(rst), .signed_div_i(s32), .opdata_1_i(a32), .opdata_2_i(b32),
        .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32),
        .div_by_zero_o(dbz32), .busy_o(busy32)
    );

    div_iter_param #(.WIDTH(8), .SIGNED_EN(0)) u_dut8 (
        .clk(clk), .rst(rst), .signed_div_i(s8), .opdata_1_i(a8), .opdata_2_i(b8),
        .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8),
        .div_by_zero_o(dbz8), .busy_o(busy8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Truncating division: quotient toward zero, remainder follows the dividend.
    function automatic logic [63:0] ref32(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return 16'd0;
        return {a % b, a / b};
    endfunction

    // drop_at: cycle after capture at which start is released early (-1 = hold).
    task automatic run32(input bit s, input logic [31:0] a, input logic [31:0] b, input int drop_at);
        logic [63:0] exp;
        int lat, exp_lat;
        exp     = ref32(s, a, b);
        exp_lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        s32 = s; a32 = a; b32 = b; st32 = 1'b1;
        @(posedge clk); #1;
        chk("busy32_after_capture", busy32, 1'b1);
        @(negedge clk);
        a32 = $urandom; b32 = $urandom; s32 = ~s;
        lat = 0;
        while (rdy32 !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (lat == drop_at) st32 = 1'b0;
        end
        chk("lat32", lat, exp_lat);
        chk("res32", res32, exp);
        chk("dbz32", dbz32, (b == 32'd0));
        @(negedge clk);
        st32 = 1'b0;
        @(posedge clk); #1;
        chk("clear32", {res32, rdy32, dbz32, busy32}, 67'd0);
    endtask

    task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b, input bit repulse);
        logic [15:0] exp;
        int lat, exp_lat;
        exp     = ref8(a, b);
        exp_lat = (b == 8'd0) ? 2 : 9;
        @(negedge clk);
        s8 = s; a8 = a; b8 = b; st8 = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (rdy8 !== 1'b1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (repulse && lat == 2) st8 = 1'b0;
            if (repulse && lat == 4) begin
                st8 = 1'b1; a8 = $urandom; b8 = $urandom; s8 = ~s;
            end
        end
        chk("lat8", lat, exp_lat);
        chk("res8", res8, exp);
        chk("dbz8", dbz8, (b == 8'd0));
        @(negedge clk);
        st8 = 1'b0;
        @(posedge clk); #1;
        chk("clear8", {res8, rdy8, dbz8, busy8}, 19'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        logic        seen;
        int          n;
        logic [31:0] ra, rb;
        bit          rs;
        int          drop;

        repeat (2) @(posedge clk);
        #1;
        chk("reset32", {res32, rdy32, dbz32, busy32}, 67'd0);
        chk("reset8", {res8, rdy8, dbz8, busy8}, 19'd0);
        @(negedge clk);
        rst = 1'b0;

        run32(1'b0, 32'd100, 32'd7, -1);
        run32(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        run32(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        run32(1'b0, 32'd5, 32'd0, -1);
        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run32(1'b0, 32'd0, 32'd13, -1);
        run32(1'b1, 32'd0, 32'hFFFF_FFF0, 5);

        // Annul at cnt=10: abort, ready never rises.
        @(negedge clk);
        s32 = 1'b0; a32 = 32'd1000; b32 = 32'd7; st32 = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        an32 = 1'b1; st32 = 1'b0;
        @(posedge clk); #1;
        chk("annul_on_abort", {res32, rdy32, dbz32, busy32}, 67'd0);
        @(negedge clk);
        an32 = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rdy32 !== 1'b0 || busy32 !== 1'b0) seen = 1'b1;
        end
        chk("annul_stays_idle", seen, 1'b0);
        run32(1'b0, 32'd9, 32'd3, -1);

        // Annul in DIVZERO.
        @(negedge clk);
        a32 = 32'd4; b32 = 32'd0; st32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        an32 = 1'b1; st32 = 1'b0;
        @(posedge clk); #1;
        chk("annul_dbz", {res32, rdy32, dbz32, busy32}, 67'd0);
        @(negedge clk);
        an32 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("annul_dbz_quiet", {rdy32, dbz32}, 2'd0);

        // Reset mid-divide.
        @(negedge clk);
        a32 = 32'd77; b32 = 32'd5; st32 = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; st32 = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_on", {res32, rdy32, dbz32, busy32}, 67'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rdy32 !== 1'b0) seen = 1'b1;
        end
        chk("rst_stays_idle", seen, 1'b0);

        // Annul together with start in IDLE is not a request.
        @(negedge clk);
        a32 = 32'd50; b32 = 32'd5; st32 = 1'b1; an32 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("annul_idle", {rdy32, busy32}, 2'd0);
        @(negedge clk);
        st32 = 1'b0; an32 = 1'b0;

        // Annul in END has no effect.
        @(negedge clk);
        s32 = 1'b1; a32 = 32'hFFFF_FFEC; b32 = 32'd3; st32 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (rdy32 !== 1'b1 && n < 60);
        held = res32;
        chk("end_result", held, ref32(1'b1, 32'hFFFF_FFEC, 32'd3));
        @(negedge clk);
        an32 = 1'b1;
        @(posedge clk); #1;
        chk("annul_end_ready", rdy32, 1'b1);
        chk("annul_end_result", res32, held);
        @(negedge clk);
        an32 = 1'b0; st32 = 1'b0;
        @(posedge clk); #1;
        chk("end_release", {res32, rdy32}, 65'd0);

        // 8-bit unsigned-only instance.
        run8(1'b1, 8'hFF, 8'h10, 1'b0);
        run8(1'b1, 8'hFF, 8'h10, 1'b1);
        run8(1'b0, 8'h80, 8'h00, 1'b0);
        for (int i = 0; i < 15; i++) begin
            run8(1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), 1'($urandom));
        end

        // Randomized 32-bit divides.
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       ra = 32'd0;
                1:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
            run32(rs, ra, rb, drop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_div_iter_param
`default_nettype wire
